// File: rtl/tt_ran_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_ran_sequencer_if
// Brief    : Control/handshake bundle between pad pins, TRNG sequencer and consumer
// Revision : 1.0
// ============================================================================
interface tt_ran_sequencer_if #(
    parameter int WORD_W = 4
);
    logic              start;
    logic              ent_bit;
    logic              word_ack;
    logic              clear_fault;
    logic              ring_en;
    logic              sample_strobe;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              busy;
    logic              fault;
    logic [7:0]        word_count;

    modport slave (
        input  start, ent_bit, word_ack, clear_fault,
        output ring_en, sample_strobe, word, word_valid, busy, fault, word_count
    );

    modport master (
        output start, ent_bit, word_ack, clear_fault,
        input  ring_en, sample_strobe, word, word_valid, busy, fault, word_count
    );
endinterface
`default_nettype wire

// File: rtl/tt_ran_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tt_ran_sequencer
// Brief    : TRNG control sequencer - ring warm-up, divided sampling, word
//            packing, repetition-count health test and valid/ack hand-off
// Revision : 1.0
// ============================================================================
module tt_ran_sequencer #(
    parameter int WORD_W     = 4,
    parameter int WARMUP_CYC = 64,
    parameter int SAMPLE_DIV = 8,
    parameter int REP_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    tt_ran_sequencer_if.slave bus
);
    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [WARM_W-1:0] c_warm_last = WARM_W'(WARMUP_CYC - 1);
    localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(WORD_W - 1);
    localparam logic [REP_W-1:0]  c_rep_limit = REP_W'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARMUP  = 3'd1,
        S_COLLECT = 3'd2,
        S_HOLD    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [WARM_W-1:0]  warm_q,   warm_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [REP_W-1:0]   rep_q,    rep_d;
    logic               prev_q,   prev_d;
    logic [WORD_W-1:0]  shift_q,  shift_d;
    logic [WORD_W-1:0]  word_q,   word_d;
    logic [7:0]         count_q,  count_d;
    logic               strobe_q, strobe_d;

    logic [WORD_W:0]    shift_cat;
    logic [REP_W-1:0]   rep_next;

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        div_d     = div_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        shift_d   = shift_q;
        word_d    = word_q;
        count_d   = count_q;
        shift_cat = {shift_q, bus.ent_bit};
        // rep_q == 0 marks "no capture yet since warm-up", so the first bit always starts a run of 1
        rep_next  = ((rep_q != '0) && (bus.ent_bit == prev_q)) ? rep_q + 1'b1 : REP_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WARMUP;
                    warm_d  = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_WARMUP: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else if (warm_q == c_warm_last) begin
                    state_d = S_COLLECT;
                    div_d   = '0;
                    bit_d   = '0;
                    rep_d   = '0;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                end else if (div_q == c_div_last) begin
                    div_d   = '0;
                    prev_d  = bus.ent_bit;
                    rep_d   = rep_next;
                    shift_d = shift_cat[WORD_W-1:0];
                    // A health failure outranks word completion: the suspect word is never published
                    if (rep_next == c_rep_limit) begin
                        state_d = S_FAULT;
                    end else if (bit_q == c_bit_last) begin
                        state_d = S_HOLD;
                        bit_d   = '0;
                        word_d  = shift_cat[WORD_W-1:0];
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.word_ack) begin
                    count_d = count_q + 8'd1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = bus.start ? S_COLLECT : S_IDLE;
                end
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_d = S_IDLE;
                    rep_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        strobe_d = (state_d == S_COLLECT) && (div_d == c_div_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            warm_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            rep_q    <= '0;
            prev_q   <= 1'b0;
            shift_q  <= '0;
            word_q   <= '0;
            count_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            rep_q    <= rep_d;
            prev_q   <= prev_d;
            shift_q  <= shift_d;
            word_q   <= word_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.ring_en       = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_HOLD);
    assign bus.busy          = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_HOLD);
    assign bus.word_valid    = (state_q == S_HOLD);
    assign bus.fault         = (state_q == S_FAULT);
    assign bus.sample_strobe = strobe_q;
    assign bus.word          = word_q;
    assign bus.word_count    = count_q;
endmodule
`default_nettype wire

// File: tb/tb_tt_ran_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_ran_sequencer
// Brief    : Scoreboard bench for tt_ran_sequencer at default parameters
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tt_ran_sequencer;
    localparam int WORD_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_ran_sequencer_if #(.WORD_W(WORD_W)) bus ();

    tt_ran_sequencer #(
        .WORD_W     (WORD_W),
        .WARMUP_CYC (64),
        .SAMPLE_DIV (8),
        .REP_LIMIT  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] word;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Driver controls, written by the main sequence only
    int          ent_mode     = 0;   // 0: pattern, 1: constant one, 2: alternating
    logic [15:0] ent_pat      = '0;
    int          ent_len      = 0;
    int          acks_granted = 0;
    // Driver-owned state
    int          ent_idx      = 0;
    int          strobe_total = 0;
    int          acks_done    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Entropy and acknowledge driver: reacts to the strobe and to word_valid
    initial begin
        bus.ent_bit  = 1'b0;
        bus.word_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sample_strobe) begin
                case (ent_mode)
                    0:       bus.ent_bit = (ent_idx < ent_len) ? ent_pat[ent_idx] : 1'b0;
                    1:       bus.ent_bit = 1'b1;
                    default: bus.ent_bit = strobe_total[0];
                endcase
                if (ent_mode == 0) ent_idx++;
                strobe_total++;
            end
            if (bus.word_valid && (acks_granted > acks_done)) begin
                bus.word_ack = 1'b1;
                acks_done++;
            end else begin
                bus.word_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every new word presentation
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.word_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_word: got word=%b count=%0d at cycle %0d, expected no word",
                             bus.word, bus.word_count, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("word_value", 32'(bus.word), 32'(e.word));
                    check("word_count_at_valid", 32'(bus.word_count), 32'(e.cnt));
                    if (e.cyc >= 0) check("valid_cycle", cyc, e.cyc);
                end
            end
            prev_v = bus.word_valid;
        end
    end

    task automatic wait_words(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("words_pending_after_wait", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [3:0] w, input logic [7:0] c, input int at);
        exp_t e;
        e.word = w;
        e.cnt  = c;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    initial begin
        int         t0;
        int         n_str;
        int         last_str;
        int         k;
        logic       bad;
        logic       seen;
        logic [3:0] w_alt;

        rst             = 1'b1;
        bus.start       = 1'b1;
        bus.clear_fault = 1'b0;

        // Reset with start high
        repeat (2) @(negedge clk);
        check("rst_ring_en",       32'(bus.ring_en), 0);
        check("rst_busy",          32'(bus.busy), 0);
        check("rst_word_valid",    32'(bus.word_valid), 0);
        check("rst_fault",         32'(bus.fault), 0);
        check("rst_strobe",        32'(bus.sample_strobe), 0);
        check("rst_word",          32'(bus.word), 0);
        check("rst_word_count",    32'(bus.word_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("release_ring_en", 32'(bus.ring_en), 1);
        check("release_busy",    32'(bus.busy), 1);
        bus.start = 1'b0;
        @(negedge clk);
        check("early_abort_ring_en", 32'(bus.ring_en), 0);

        // Two words 1011 then 0100; only the first is acked immediately
        ent_pat  = 16'b0000_0000_0010_1101;
        ent_len  = 8;
        ent_mode = 0;
        t0 = cyc;
        push_exp(4'b1011, 8'd0, t0 + 97);
        push_exp(4'b0100, 8'd1, t0 + 97 + 33);
        acks_granted = acks_granted + 1;
        bus.start = 1'b1;
        wait_words(300);

        // Held word with start dropped: must stay valid and stable without acks
        bus.start = 1'b0;
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (!bus.word_valid || bus.word !== 4'b0100 || bus.sample_strobe || bus.word_count !== 8'd1)
                bad = 1'b1;
        end
        check("hold_stable_200", 32'(bad), 0);
        acks_granted = acks_granted + 1;
        repeat (3) @(negedge clk);
        check("hold_ack_idle_ring_en", 32'(bus.ring_en), 0);
        check("hold_ack_valid",        32'(bus.word_valid), 0);
        check("hold_ack_count",        32'(bus.word_count), 2);
        check("hold_ack_word",         32'(bus.word), 32'h4);

        // Stuck-at-one entropy: one word, then fault on the 8th capture
        ent_mode = 1;
        push_exp(4'b1111, 8'd2, -1);
        acks_granted = acks_granted + 1;
        bus.start = 1'b1;
        n_str = 0;
        last_str = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.fault) seen = 1'b1;
            else if (bus.sample_strobe) begin
                n_str++;
                last_str = cyc;
            end
        end
        check("fault_reached",       32'(seen), 1);
        check("strobes_to_fault",    n_str, 8);
        check("fault_one_cycle",     cyc - last_str, 1);
        check("fault_ring_en",       32'(bus.ring_en), 0);
        check("fault_busy",          32'(bus.busy), 0);
        check("fault_word_valid",    32'(bus.word_valid), 0);
        check("fault_word",          32'(bus.word), 32'hF);
        check("fault_word_count",    32'(bus.word_count), 3);
        check("fault_first_word_out", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        check("fault_sticky", 32'(bus.fault), 1);
        bus.start = 1'b0;
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        check("clear_fault_fault",   32'(bus.fault), 0);
        check("clear_fault_ring_en", 32'(bus.ring_en), 0);
        check("clear_fault_count",   32'(bus.word_count), 3);
        bus.start = 1'b1;
        @(negedge clk);
        check("rewarm_ring_en", 32'(bus.ring_en), 1);

        // Abort at warm-up cycle 40
        bad = 1'b0;
        repeat (39) begin
            @(negedge clk);
            if (!bus.busy || bus.sample_strobe) bad = 1'b1;
        end
        check("warmup_before_abort", 32'(bad), 0);
        bus.start = 1'b0;
        @(negedge clk);
        check("warm_abort_ring_en", 32'(bus.ring_en), 0);
        check("warm_abort_word",    32'(bus.word), 32'hF);
        check("warm_abort_count",   32'(bus.word_count), 3);

        // Abort at the 2nd strobe of collection
        ent_mode = 2;
        bus.start = 1'b1;
        n_str = 0;
        for (int i = 0; i < 200 && n_str < 2; i++) begin
            @(negedge clk);
            if (bus.sample_strobe) n_str++;
        end
        bus.start = 1'b0;
        check("collect_abort_strobes", n_str, 2);
        @(negedge clk);
        check("collect_abort_ring_en", 32'(bus.ring_en), 0);
        check("collect_abort_valid",   32'(bus.word_valid), 0);
        check("collect_abort_word",    32'(bus.word), 32'hF);
        check("collect_abort_count",   32'(bus.word_count), 3);

        // Reset mid-life, then 256 acked alternating words to wrap word_count
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rerst_word_count", 32'(bus.word_count), 0);
        check("rerst_word",       32'(bus.word), 0);
        w_alt = strobe_total[0] ? 4'b1010 : 4'b0101;
        t0 = cyc;
        for (k = 0; k < 256; k++) push_exp(w_alt, 8'(k), t0 + 97 + 33 * k);
        acks_granted = acks_granted + 256;
        bus.start = 1'b1;
        wait_words(97 + 33 * 256 + 50);
        for (int i = 0; i < 10 && bus.word_valid; i++) @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("wrap_word_count", 32'(bus.word_count), 0);
        check("wrap_fault",      32'(bus.fault), 0);
        check("wrap_idle",       32'(bus.ring_en), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/tt_ran_sequencer.md
Name: tt_ran_sequencer

Overview:
Control sequencer for the TRNG entropy path: gates the inverter ring, waits out a warm-up period, then samples the whitened entropy bit at a fixed divided rate. Sampled bits are packed into a WORD_W-bit key. A repetition-count health test runs on every sampled bit, and each finished word is handed off on a valid/ack handshake. It sits between the pad-level control pins and the ring / sample / display blocks, replacing direct pin control of startring and sample.

Parameters:
WORD_W, 4, bits per delivered word (matches the 4-bit display key); legal 1..16
WARMUP_CYC, 64, clk cycles the ring runs before the first sample; legal >= 1
SAMPLE_DIV, 8, clk cycles between consecutive samples; legal >= 1
REP_LIMIT, 8, consecutive identical sampled bits that declare a fault; legal >= 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  level request: run generation while high
ent_bit  input  1  whitened entropy bit (ring-processed XOR LFSR), already synchronous to clk
word_ack  input  1  consumer accepts the word held on word
clear_fault  input  1  one-cycle pulse to leave FAULT
ring_en  output  1  enable to the inverter ring (drives startring)
sample_strobe  output  1  one-cycle pulse in the cycle ent_bit is captured
word  output  WORD_W  packed key; first sampled bit is the MSB
word_valid  output  1  word is complete and stable
busy  output  1  high in WARMUP, COLLECT and HOLD
fault  output  1  health test failed; sticky
word_count  output  8  number of words delivered; wraps 255->0

Behaviour:
- Reset (rst=1 at an edge) forces state IDLE. Every output goes to 0, including word and word_count. The divider, bit counter, repetition counter and previous-bit register are cleared. Reset has priority over every other input in every state.
- States: IDLE, WARMUP, COLLECT, HOLD, FAULT. All outputs are registered or decoded from the state only; there is no combinational path from input to output.
- IDLE: ring_en=0. start=1 at an edge moves to WARMUP and clears the warm-up counter.
- WARMUP: ring_en=1. Lasts exactly WARMUP_CYC cycles, then moves to COLLECT with the divider, bit counter and repetition counter cleared.
- COLLECT: ring_en=1. The divider counts 0..SAMPLE_DIV-1.
  - In the cycle the divider is at SAMPLE_DIV-1, sample_strobe=1. At the end of that cycle ent_bit is shifted into the shift register LSB (shift left), and the bit counter increments.
  - Health test on each capture: if ent_bit equals the previous sampled bit, rep_cnt increments, otherwise rep_cnt is reset to 1. The first capture after WARMUP sets rep_cnt=1.
  - rep_cnt reaching REP_LIMIT moves to FAULT.
  - The WORD_W-th capture loads word and moves to HOLD.
  - If a capture both completes the word and trips the test, FAULT wins: word is not updated and word_valid stays 0.
- HOLD: ring_en=1, word_valid=1, word stable. No sampling occurs.
  - word_ack=1 at an edge: word_valid drops next cycle and word_count increments.
  - After the ack, if start=1 the block returns to COLLECT without a warm-up. rep_cnt and the previous bit carry over, so the health test spans word boundaries. If start=0 it returns to IDLE.
  - word_ack outside HOLD is ignored.
- FAULT: ring_en=0, fault=1, word_valid=0, busy=0. Only clear_fault (or rst) leaves FAULT, moving to IDLE and clearing rep_cnt. word_count is retained.
- Abort: start=0 in WARMUP or COLLECT moves to IDLE at that edge. Partial bits are discarded, word keeps its last delivered value, and no strobe is issued in the abort cycle.
- start=0 during HOLD does not abort. The held word stays valid until it is acked.
- Latency: with start rising at edge 0 and no fault, word_valid rises 1 + WARMUP_CYC + WORD_W*SAMPLE_DIV cycles later (97 cycles at defaults). Steady-state word period with an immediate ack is WORD_W*SAMPLE_DIV + 1 cycles.
- word_count is 8-bit unsigned and wraps modulo 256.

Test Plan:
1. Assert rst for 2 cycles with start=1 -> all outputs 0 and state IDLE. Release rst -> ring_en rises 1 cycle later.
2. Defaults, start held high, ent_bit driven so captures are 1,0,1,1, ack in the same cycle as valid -> word_valid rises exactly 97 cycles after start, word=4'b1011, word_count=1. The next valid follows 33 cycles after the ack.
3. ent_bit tied to 1, start held high -> the 8th strobe drives fault=1 and ring_en=0 on the next cycle, with word_valid never set after word 1. A clear_fault pulse returns to IDLE with fault=0, and start=1 then re-enters WARMUP.
4. Drop start at cycle 40 of WARMUP and at the 2nd strobe of COLLECT -> IDLE on the next cycle, no word_valid, word unchanged, word_count unchanged.
5. Hold word_ack=0 for 200 cycles in HOLD while dropping start -> word and word_valid stay stable and sample_strobe stays 0. A single ack then gives IDLE with word_count+1.
6. Run 256 acked words with alternating bits -> word_count wraps to 0 and fault never asserts.
